// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed seven-segment driver: latches a binary value, converts it
// to BCD with a sequential shift-add-3, and scans the digits with a dead time per digit.
module fnd_scan_driver #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic [13:0] i_value,
   input  logic [3:0]  i_dp,
   input  logic        i_blank_lz,
   output logic [3:0]  o_fndDigit,
   output logic [7:0]  o_fndFont,
   output logic        o_busy,
   output logic        o_ovf
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
   localparam logic [13:0]      VAL_MAX   = 14'd9999;

   typedef enum logic {
      S_IDLE,
      S_CONV
   } state_t;

   function automatic logic [13:0] sat_9999(input logic [13:0] v);
      return (v > VAL_MAX) ? VAL_MAX : v;
   endfunction

   // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
   function automatic logic [15:0] bcd_step(input logic [15:0] b, input logic bit_in);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return {r[14:0], bit_in};
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   state_t           state;
   state_t           state_nxt;
   logic             conv_done;
   logic             load_acc;
   logic [3:0]       bit_cnt;
   logic [13:0]      bin_sh;
   logic [15:0]      bcd_sh;
   logic [15:0]      bcd_next;
   logic [3:0]       dp_lat;

   logic [15:0]      pend_bcd;
   logic [3:0]       pend_dp;
   logic             pend_vld;
   logic [15:0]      disp_bcd;
   logic [3:0]       disp_dp;

   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic             scan_tick;
   logic             frame_end;

   logic [3:0]       lz;
   logic [3:0]       cur_digit;
   logic             drive_p0;
   logic [3:0]       digit_p0;
   logic [7:0]       font_p0;
   logic [3:0]       digit_p1;
   logic [7:0]       font_p1;

   assign load_acc = i_load && (state == S_IDLE);
   assign o_busy   = (state == S_CONV);
   assign bcd_next = bcd_step(bcd_sh, bin_sh[13]);

   // ---- conversion control ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         o_ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_acc) begin
            bit_cnt <= '0;
            o_ovf   <= (i_value > VAL_MAX);
         end else if (state == S_CONV) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      conv_done = 1'b0;
      case (state)
         S_IDLE: if (i_load) state_nxt = S_CONV;
         S_CONV: begin
            if (bit_cnt == 4'd13) begin
               state_nxt = S_IDLE;
               conv_done = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (load_acc) begin
         bin_sh <= sat_9999(i_value);
         bcd_sh <= '0;
         dp_lat <= i_dp;
      end else if (state == S_CONV) begin
         bin_sh <= {bin_sh[12:0], 1'b0};
         bcd_sh <= bcd_next;
      end
   end

   // ---- scan timing, pending and display registers ----
   assign scan_tick = (cnt == CNT_MAX);
   assign frame_end = scan_tick && (idx == 2'd3);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         pend_bcd <= '0;
         pend_dp  <= '0;
         pend_vld <= 1'b0;
         disp_bcd <= '0;
         disp_dp  <= '0;
      end else begin
         cnt <= scan_tick ? '0 : cnt + CNT_W'(1);
         if (scan_tick)
            idx <= idx + 2'd1;
         // The frame swap sees the pending value from before this edge.
         if (frame_end && pend_vld) begin
            disp_bcd <= pend_bcd;
            disp_dp  <= pend_dp;
         end
         if (conv_done) begin
            pend_bcd <= bcd_next;
            pend_dp  <= dp_lat;
            pend_vld <= 1'b1;
         end else if (frame_end) begin
            pend_vld <= 1'b0;
         end
      end
   end

   // ---- segment decode (p0) ----
   always_comb begin
      lz    = 4'b0000;
      lz[3] = (disp_bcd[15:12] == 4'd0);
      lz[2] = lz[3] && (disp_bcd[11:8] == 4'd0);
      lz[1] = lz[2] && (disp_bcd[7:4] == 4'd0);
   end

   assign cur_digit = disp_bcd[{idx, 2'b00} +: 4];
   assign drive_p0  = (cnt >= BLANK_LIM) && !(i_blank_lz && lz[idx]);
   assign digit_p0  = drive_p0 ? ~(4'b0001 << idx) : 4'hF;
   assign font_p0   = drive_p0 ? {~disp_dp[idx], seg7(cur_digit)} : 8'hFF;

   // ---- output register (p1) ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         digit_p1 <= 4'hF;
         font_p1  <= 8'hFF;
      end else begin
         digit_p1 <= digit_p0;
         font_p1  <= font_p0;
      end
   end

   assign o_fndDigit = digit_p1;
   assign o_fndFont  = font_p1;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame).
module tb_fnd_scan_driver;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [13:0] value;
   logic [3:0]  dp;
   logic        blz;
   logic [3:0]  o_fndDigit;
   logic [7:0]  o_fndFont;
   logic        o_busy;
   logic        o_ovf;

   int nvec;
   int nerr;
   int cyc;

   fnd_scan_driver #(
      .SCAN_DIV  (8),
      .BLANK_CYC (2)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_load     (load),
      .i_value    (value),
      .i_dp       (dp),
      .i_blank_lz (blz),
      .o_fndDigit (o_fndDigit),
      .o_fndFont  (o_fndFont),
      .o_busy     (o_busy),
      .o_ovf      (o_ovf)
   );

   always #5 clk = ~clk;

   // Edges since reset release; pins seen after edge k reflect scan phase (k-1) mod 32.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [11:0] exp_pins(input int k, input logic [15:0] disp,
                                            input logic [3:0] dpv, input logic lzb);
      int         p;
      int         di;
      int         slot;
      logic [3:0] d;
      logic [3:0] sel;
      logic [7:0] f;
      logic       zero_up;
      p    = (k - 1) % 32;
      di   = p / 8;
      slot = p % 8;
      if (slot < 2) return 12'hFFF;
      zero_up = 1'b1;
      for (int i = di; i < 4; i++)
         if (disp[4*i +: 4] != 4'd0) zero_up = 1'b0;
      if (lzb && di >= 1 && zero_up) return 12'hFFF;
      d = disp[4*di +: 4];
      case (d)
         4'd0: f = 8'hC0;
         4'd1: f = 8'hF9;
         4'd2: f = 8'hA4;
         4'd3: f = 8'hB0;
         4'd4: f = 8'h99;
         4'd5: f = 8'h92;
         4'd6: f = 8'h82;
         4'd7: f = 8'hF8;
         4'd8: f = 8'h80;
         4'd9: f = 8'h90;
         default: f = 8'hFF;
      endcase
      f[7] = ~dpv[di];
      sel = 4'hF;
      sel[di] = 1'b0;
      return {sel, f};
   endfunction

   // Move to the first negedge of a frame, at least two cycles ahead.
   task automatic align_frame();
      repeat (2) @(negedge clk);
      while ((cyc - 1) % 32 != 0) @(negedge clk);
   endtask

   task automatic test_reset();
      clk = 1'b0; rst_n = 1'b1; load = 1'b0; value = '0; dp = '0; blz = 1'b0;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      nvec++;
      if (o_fndDigit !== 4'hF) begin
         nerr++; $display("FAIL reset_digit got %h expected F", o_fndDigit);
      end
      nvec++;
      if (o_fndFont !== 8'hFF) begin
         nerr++; $display("FAIL reset_font got %h expected FF", o_fndFont);
      end
      nvec++;
      if (o_busy !== 1'b0) begin
         nerr++; $display("FAIL reset_busy got %b expected 0", o_busy);
      end
      nvec++;
      if (o_ovf !== 1'b0) begin
         nerr++; $display("FAIL reset_ovf got %b expected 0", o_ovf);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle_scan();
      logic [11:0] e;
      for (int j = 0; j < 64; j++) begin
         @(negedge clk);
         e = exp_pins(cyc, 16'h0000, 4'b0000, blz);
         nvec++;
         if ({o_fndDigit, o_fndFont} !== e) begin
            nerr++;
            $display("FAIL idle_scan cyc=%0d lz=%b got %h expected %h", cyc, blz,
                     {o_fndDigit, o_fndFont}, e);
         end
         if (j == 31) blz = 1'b1;
      end
      blz = 1'b0;
   endtask

   task automatic test_load_1234();
      logic [11:0] e;
      @(negedge clk);
      value = 14'd1234; dp = 4'b0100; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int j = 0; j < 14; j++) begin
         if (j > 0) @(negedge clk);
         nvec++;
         if (o_busy !== 1'b1) begin
            nerr++; $display("FAIL busy_1234 cycle %0d got %b expected 1", j, o_busy);
         end
      end
      @(negedge clk);
      nvec++;
      if (o_busy !== 1'b0) begin
         nerr++; $display("FAIL busy_end_1234 got %b expected 0", o_busy);
      end
      nvec++;
      if (o_ovf !== 1'b0) begin
         nerr++; $display("FAIL ovf_1234 got %b expected 0", o_ovf);
      end
      dp = 4'b0000;
      align_frame();
      for (int j = 0; j < 32; j++) begin
         if (j > 0) @(negedge clk);
         e = exp_pins(cyc, 16'h1234, 4'b0100, 1'b0);
         nvec++;
         if ({o_fndDigit, o_fndFont} !== e) begin
            nerr++;
            $display("FAIL scan_1234 cyc=%0d got %h expected %h", cyc, {o_fndDigit, o_fndFont}, e);
         end
      end
   endtask

   task automatic test_overflow();
      logic [11:0] e;
      @(negedge clk);
      value = 14'd12000; dp = 4'b0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      nvec++;
      if (o_ovf !== 1'b1) begin
         nerr++; $display("FAIL ovf_12000 got %b expected 1", o_ovf);
      end
      repeat (14) @(negedge clk);
      nvec++;
      if (o_busy !== 1'b0) begin
         nerr++; $display("FAIL busy_end_12000 got %b expected 0", o_busy);
      end
      align_frame();
      for (int j = 0; j < 32; j++) begin
         if (j > 0) @(negedge clk);
         e = exp_pins(cyc, 16'h9999, 4'b0000, 1'b0);
         nvec++;
         if ({o_fndDigit, o_fndFont} !== e) begin
            nerr++;
            $display("FAIL scan_sat cyc=%0d got %h expected %h", cyc, {o_fndDigit, o_fndFont}, e);
         end
      end
      value = 14'd5; load = 1'b1; blz = 1'b1;
      @(negedge clk);
      load = 1'b0;
      nvec++;
      if (o_ovf !== 1'b0) begin
         nerr++; $display("FAIL ovf_5 got %b expected 0", o_ovf);
      end
      repeat (14) @(negedge clk);
      align_frame();
      for (int j = 0; j < 32; j++) begin
         if (j > 0) @(negedge clk);
         e = exp_pins(cyc, 16'h0005, 4'b0000, 1'b1);
         nvec++;
         if ({o_fndDigit, o_fndFont} !== e) begin
            nerr++;
            $display("FAIL scan_lz5 cyc=%0d got %h expected %h", cyc, {o_fndDigit, o_fndFont}, e);
         end
      end
      blz = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [11:0] e;
      align_frame();
      for (int j = 0; j < 64; j++) begin
         if (j > 0) @(negedge clk);
         e = exp_pins(cyc, (j < 32) ? 16'h0005 : 16'h0099, 4'b0000, 1'b0);
         nvec++;
         if ({o_fndDigit, o_fndFont} !== e) begin
            nerr++;
            $display("FAIL b2b_scan cyc=%0d got %h expected %h", cyc, {o_fndDigit, o_fndFont}, e);
         end
         if (j == 14) begin
            nvec++;
            if (o_busy !== 1'b1) begin
               nerr++; $display("FAIL b2b_busy_first got %b expected 1", o_busy);
            end
         end
         if (j == 15) begin
            nvec++;
            if (o_busy !== 1'b0) begin
               nerr++; $display("FAIL b2b_busy_gap got %b expected 0", o_busy);
            end
         end
         case (j)
            0:  begin value = 14'd42; load = 1'b1; end
            15: begin value = 14'd99; load = 1'b1; end
            default: load = 1'b0;
         endcase
      end
   endtask

   task automatic test_busy_ignore();
      logic [11:0] e;
      @(negedge clk);
      value = 14'd42; dp = 4'b0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int j = 0; j < 14; j++) begin
         if (j > 0) @(negedge clk);
         nvec++;
         if (o_busy !== 1'b1) begin
            nerr++; $display("FAIL ign_busy cycle %0d got %b expected 1", j, o_busy);
         end
         if (j == 3) begin value = 14'd7777; dp = 4'b1111; load = 1'b1; end
         else begin load = 1'b0; dp = 4'b0000; end
      end
      @(negedge clk);
      nvec++;
      if (o_busy !== 1'b0) begin
         nerr++; $display("FAIL ign_busy_end got %b expected 0", o_busy);
      end
      align_frame();
      for (int j = 0; j < 32; j++) begin
         if (j > 0) @(negedge clk);
         e = exp_pins(cyc, 16'h0042, 4'b0000, 1'b0);
         nvec++;
         if ({o_fndDigit, o_fndFont} !== e) begin
            nerr++;
            $display("FAIL ign_scan cyc=%0d got %h expected %h", cyc, {o_fndDigit, o_fndFont}, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] e;
      align_frame();
      value = 14'd12000; dp = 4'b0000; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      e = exp_pins(cyc, 16'h0042, 4'b0000, 1'b0);
      nvec++;
      if ({o_fndDigit, o_fndFont} !== e) begin
         nerr++;
         $display("FAIL mid_pre_drive got %h expected %h", {o_fndDigit, o_fndFont}, e);
      end
      nvec++;
      if ({o_busy, o_ovf} !== 2'b11) begin
         nerr++; $display("FAIL mid_pre_busy_ovf got %b expected 11", {o_busy, o_ovf});
      end
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({o_fndDigit, o_fndFont} !== 12'hFFF) begin
         nerr++;
         $display("FAIL mid_rst_pins got %h expected fff", {o_fndDigit, o_fndFont});
      end
      nvec++;
      if ({o_busy, o_ovf} !== 2'b00) begin
         nerr++; $display("FAIL mid_rst_busy_ovf got %b expected 00", {o_busy, o_ovf});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 64; j++) begin
         @(negedge clk);
         e = exp_pins(cyc, 16'h0000, 4'b0000, 1'b0);
         nvec++;
         if ({o_fndDigit, o_fndFont, o_busy} !== {e, 1'b0}) begin
            nerr++;
            $display("FAIL mid_after cyc=%0d got %h/%b expected %h/0", cyc,
                     {o_fndDigit, o_fndFont}, o_busy, e);
         end
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      test_reset();
      test_idle_scan();
      test_load_1234();
      test_overflow();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
